mdr_sequencer: RTL
==================

// Module: mdr_sequencer
// PURPOSE
//   Control FSM + iteration engine for the MDR (multiply/divide/root) unit. Accepts one unsigned
//   16-bit operation per start pulse and runs an iterative radix-2 datapath for a fixed number of
//   cycles. Returns a 32-bit prod_t result with done/err status.
//   Sits between the operand/op capture logic and the BCD/7-segment display path.
// PARAMETERS
//   W_DATA   16   operand width (taken from definitions_pkg; not overridden per instance)
//   N_MUL    16   RUN iterations for MUL (= W_DATA)
//   N_DIV    16   RUN iterations for DIV (= W_DATA)
//   N_SQRT   8    RUN iterations for SQRT (= W_DATA/2)
// PORTS
//   clk      in   1       single clock, rising edge
//   rst      in   1       synchronous, active-high reset
//   start    in   1       request pulse; accepted only in IDLE
//   op       in   op_t    2'b00 MUL, 2'b01 DIV, 2'b10 SQRT, 2'b11 reserved
//   data_x   in   data_t  multiplicand / dividend / radicand
//   data_y   in   data_t  multiplier / divisor; ignored for SQRT
//   busy     out  1       high from the accepting edge until done
//   done     out  1       one-cycle pulse; result/err valid from this cycle on
//   err      out  1       DIV by zero or reserved op; held with result
//   result   out  prod_t  MUL: product; DIV: {rem[15:0],quot[15:0]}; SQRT: {rem[15:0],16'(root[7:0])}
// BEHAVIOUR
//   Reset: rst=1 at an edge -> state IDLE, busy=0, done=0, err=0, result=0, counter=0.
//     Reset has priority over every other input, including in the middle of RUN.
//   States:
//     IDLE -> LOAD     on start=1.
//       - Capture op, data_x and data_y into internal registers.
//       - busy=1 from the next cycle.
//     LOAD -> ERR      if op==2'b11, or if op==DIV with data_y==0.
//     LOAD -> RUN      otherwise.
//       - Clear the accumulator and partial remainder.
//       - Load counter with N_op-1.
//     RUN  -> RUN      one datapath step per cycle while counter!=0; counter decrements.
//     RUN  -> DONE     when counter==0 and that final step is taken.
//     ERR  -> DONE     err=1, result=32'h0.
//     DONE -> IDLE     unconditionally.
//       - done=1 and busy=0 in DONE.
//       - err=0 on a normal completion.
//   Latency (start sampled at edge k):
//     MUL and DIV done at cycle k+18; SQRT at k+10; error at k+3.
//     Next start is accepted in the cycle after DONE.
//   Hold: result and err stay stable after done until the next accepted start, then clear to 0.
//   start while busy (LOAD/RUN/ERR/DONE) is ignored; nothing queues. Inputs are only sampled at acceptance.
//   Arithmetic: all unsigned; no wrap possible.
//     MUL: shift-add into a 32-bit accumulator, LSB of the multiplier first.
//     DIV: restoring division with a 17-bit partial remainder, MSB of the dividend first.
//     SQRT: restoring digit-by-digit, 2 radicand bits per step; root 8 bits, remainder <= 2*root.
//   done is never asserted on two consecutive cycles.
// STRUCTURE
//   definitions_pkg additions:
//     - mdr_state_t enum: IDLE, LOAD, RUN, ERR, DONE.
//     - localparams OP_MUL, OP_DIV, OP_SQRT, OP_RSVD of type op_t.
//     - N_MUL, N_DIV, N_SQRT iteration counts.
//     - cnt_t = logic [$clog2(W_DATA)-1:0].
//   mdr_sequencer holds the FSM, iteration counter and operand/result registers.
//   Sub-module mdr_iter_dp: combinational single-step ALU (mul/div/sqrt step selected by op).
//     Takes the current accumulator/remainder/operand, returns the next values.
//     Registered by the sequencer.
// TESTING
//   1. MUL 16'hFFFF x 16'hFFFF, start at edge k -> done at k+18, result=32'hFFFE_0001, err=0.
//   2. DIV 1000 / 7 -> result=32'h0006_008E (q=142, r=6), err=0, done at k+18.
//   3. SQRT 1024 -> result=32'h0000_0020; SQRT 1000 -> result=32'h0027_001F; done at k+10.
//   4. DIV 500 / 0 -> done at k+3, err=1, result=0; then op=2'b11 -> same err response.
//   5. start re-pulsed at k+5 with new operands during MUL 3x4 -> ignored.
//      result=32'h0000_000C at k+18, busy continuous from k+1 to k+17.
//   6. rst at k+8 of a DIV -> next cycle IDLE, busy/done/err=0, result=0.
//      A fresh start then completes normally.

Source files
------------

// File: rtl/mdr_sequencer_pkg.sv
// mdr_sequencer_pkg: shared types, opcodes and iteration counts for the MDR unit
package mdr_sequencer_pkg;
  localparam int W_DATA = 16;
  localparam int N_MUL = W_DATA;
  localparam int N_DIV = W_DATA;
  localparam int N_SQRT = W_DATA / 2;
  typedef logic [W_DATA-1:0] data_t;
  typedef logic [2*W_DATA-1:0] prod_t;
  typedef logic [1:0] op_t;
  typedef logic [$clog2(W_DATA)-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, ERR, DONE} mdr_state_t;
  localparam op_t OP_MUL = 2'b00;
  localparam op_t OP_DIV = 2'b01;
  localparam op_t OP_SQRT = 2'b10;
  localparam op_t OP_RSVD = 2'b11;
  function automatic cnt_t iter_last(input op_t op);
    return op == OP_SQRT ? cnt_t'(N_SQRT - 1) : op == OP_DIV ? cnt_t'(N_DIV - 1) : cnt_t'(N_MUL - 1);
  endfunction
endpackage

// File: rtl/mdr_iter_dp.sv
// mdr_iter_dp: one combinational radix-2 step of multiply, divide or square root
module mdr_iter_dp
  import mdr_sequencer_pkg::*;
(
  input  op_t   op,
  input  cnt_t  cnt,
  input  data_t x,
  input  data_t y,
  input  prod_t acc,
  input  data_t rem,
  output prod_t acc_n,
  output data_t rem_n
);
  cnt_t mi;
  prod_t mul_sum;
  logic [W_DATA:0] div_t;
  logic [W_DATA:0] div_d;
  logic [W_DATA+1:0] sq_t;
  logic [W_DATA+1:0] sq_d;
  logic div_ge;
  logic sq_ge;
  // MUL walks the multiplier LSB first; DIV and SQRT walk the operand MSB first via cnt
  assign mi = cnt_t'(N_MUL - 1) - cnt;
  assign mul_sum = acc + (y[mi] ? prod_t'(x) << mi : '0);
  assign div_t = {rem, x[cnt]};
  assign div_d = {1'b0, y};
  assign div_ge = div_t >= div_d;
  assign sq_t = {rem, x[{cnt[2:0], 1'b0} +: 2]};
  assign sq_d = {8'b0, acc[7:0], 2'b01};
  assign sq_ge = sq_t >= sq_d;
  always_comb begin
    acc_n = op == OP_MUL ? mul_sum : op == OP_DIV ? {acc[2*W_DATA-2:0], div_ge} : {acc[2*W_DATA-2:0], sq_ge};
    rem_n = op == OP_MUL ? rem
          : op == OP_DIV ? data_t'(div_ge ? div_t - div_d : div_t)
          : data_t'(sq_ge ? sq_t - sq_d : sq_t);
  end
endmodule

// File: rtl/mdr_sequencer.sv
// mdr_sequencer: control FSM and iteration engine for multiply/divide/root
module mdr_sequencer
  import mdr_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  op_t   op,
  input  data_t data_x,
  input  data_t data_y,
  output logic  busy,
  output logic  done,
  output logic  err,
  output prod_t result
);
  mdr_state_t state, state_n;
  op_t op_q;
  data_t x_q, y_q, rem, rem_n;
  prod_t acc, acc_n;
  cnt_t cnt;
  logic bad;
  mdr_iter_dp u_dp (
    .op(op_q), .cnt(cnt), .x(x_q), .y(y_q),
    .acc(acc), .rem(rem), .acc_n(acc_n), .rem_n(rem_n)
  );
  assign bad = op_q == OP_RSVD || (op_q == OP_DIV && y_q == '0);
  assign busy = state == LOAD || state == RUN || state == ERR;
  assign done = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? LOAD : IDLE)
            : state == LOAD ? (bad ? ERR : RUN)
            : state == RUN  ? (cnt == '0 ? DONE : RUN)
            : state == ERR  ? DONE
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_MUL;
      x_q <= '0;
      y_q <= '0;
      acc <= '0;
      rem <= '0;
      cnt <= '0;
      err <= 1'b0;
      result <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_q <= op;
        x_q <= data_x;
        y_q <= data_y;
        err <= 1'b0;
        result <= '0;
      end
      if (state == LOAD) begin
        acc <= '0;
        rem <= '0;
        cnt <= iter_last(op_q);
      end
      if (state == RUN) begin
        acc <= acc_n;
        rem <= rem_n;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
      end
      if (state == RUN && cnt == '0)
        result <= op_q == OP_MUL ? acc_n
                : op_q == OP_DIV ? {rem_n, acc_n[W_DATA-1:0]}
                : {rem_n, 8'b0, acc_n[7:0]};
      if (state == ERR) begin
        err <= 1'b1;
        result <= '0;
      end
    end
  end
endmodule
